mux4_rr_sequencer: RTL and testbench
====================================

Name: mux4_rr_sequencer

Overview:
- Control stage directly upstream of the 8-bit 4:1 multiplexer (select `s[1:0]`, inputs a/b/c/d, output z).
- Arbitrates round-robin among four requesting sources and drives the mux select.
- Samples the mux output one cycle after the select is applied.
- Presents the captured word downstream on a valid/ready handshake and acks the served source.

Parameters:
- W, 8, data width of the mux output sampled back (z) and of out_data.
- CNT_W, 8, width of the wrapping transfer counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req  input  4  request per source; bit0 = a, bit1 = b, bit2 = c, bit3 = d; level-sensitive.
- z  input  W  mux output, fed back from the downstream mux.
- s  output  2  mux select, registered.
- out_data  output  W  captured word, registered.
- out_valid  output  1  out_data holds an unaccepted word.
- out_ready  input  1  downstream accepts out_data this cycle.
- ack  output  4  one-hot, one-cycle pulse to the served source on transfer.
- busy  output  1  high whenever the FSM is not in IDLE.
- xfer_cnt  output  CNT_W  number of completed transfers, wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - s = 2'b00, out_data = 0, out_valid = 0, ack = 0, xfer_cnt = 0, state = IDLE.
  - Round-robin pointer last = 2'd3, so source 0 has top priority after reset.
- FSM states: IDLE, SEL, HOLD. busy = (state != IDLE).
- IDLE:
  - If req == 0, stay in IDLE; s holds its value.
  - Otherwise grant the first set bit scanning last+1, last+2, last+3, last+4 (mod 4).
  - Register s <= grant; go to SEL.
- SEL (one cycle; the mux settles combinationally on the new s):
  - out_data <= z; out_valid <= 1; go to HOLD.
  - The grant is committed: a req drop during SEL does not cancel the capture.
- HOLD:
  - out_valid stays 1 and out_data stays stable until out_ready is 1.
  - On a clock edge with out_ready = 1:
    - out_valid <= 0.
    - ack[s] <= 1 for exactly one cycle.
    - last <= s.
    - xfer_cnt <= xfer_cnt + 1 (wraps from 2^CNT_W-1 to 0).
    - Go to IDLE.
  - If out_ready = 0, hold indefinitely; req changes are ignored.
- ack is 0 in every cycle other than the one after a transfer.
- Latency:
  - Request seen in IDLE -> out_valid high 2 cycles later.
  - Minimum 3 cycles per transfer with out_ready tied high.
  - One transfer at a time; no buffering beyond out_data.
- s changes only on the IDLE->SEL edge. It holds through HOLD and IDLE so the mux output stays defined.
- Simultaneous requests: exactly one grant per arbitration, by pointer order.
  - A source that keeps its req asserted after ack is served again only after all other asserted sources.
- out_ready asserted while out_valid = 0 has no effect.
- Reset mid-operation (any state): abort immediately to reset values.
  - The pending word is discarded and no ack is issued.

Test Plan:
- Reset then single request: mux inputs a=00, b=0F, c=F0, d=FF; req=0100, out_ready=1.
  - Required: s=10 one cycle after req is seen; out_valid=1 with out_data=F0 the next cycle.
  - Required: ack=0100 for one cycle; xfer_cnt=1.
- Round-robin with all requesting: req=1111 held, out_ready=1.
  - Required: grants in order 0,1,2,3,0.
  - Required: out_data sequence 00, 0F, F0, FF, 00; ack pulses 0001, 0010, 0100, 1000, 0001.
- Backpressure: req=1000, out_ready=0 for 5 cycles, then 1.
  - Required: out_valid=1 and out_data=FF stable for all 5 cycles; s stays 11.
  - Required: single ack=1000 only after out_ready rises; req changes during the hold are ignored.
- Request dropped in SEL: req=0010 for exactly one cycle.
  - Required: transfer still completes with out_data=0F and ack=0010; FSM returns to IDLE, busy=0.
- Async reset mid-HOLD: assert rst_n=0 between clock edges while out_valid=1.
  - Required: out_valid, ack and s go to 0 immediately, without waiting for clk.
  - Required: after release with req=1111, the first grant goes to source 0.
- Counter wrap: 256 transfers with CNT_W=8.
  - Required: xfer_cnt reads 255 then 0; no effect on grant order.

Source files
------------

// File: rtl/mux4_rr_sequencer.sv
`default_nettype none
// ============================================================================
// mux4_rr_sequencer : round-robin select driver for a 4:1 mux, valid/ready out
// Revision 1.0
// ============================================================================
module mux4_rr_sequencer #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [W-1:0]     z,
    output logic [1:0]       s,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       ack,
    output logic             busy,
    output logic [CNT_W-1:0] xfer_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       s_q, s_d;
    logic [1:0]       last_q, last_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [3:0]       ack_q, ack_d;
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

    logic [1:0]       grant;
    logic [1:0]       idx;
    logic             found;

    // Scan last+1 .. last+4 so the most recently served source comes last.
    always_comb begin
        grant = last_q;
        idx   = last_q;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last_q + 2'(i);
            if (!found && req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        last_d      = last_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ack_d       = 4'b0000;
        xfer_cnt_d  = xfer_cnt_q;
        case (state_q)
            IDLE: begin
                if (req != 4'b0000) begin
                    s_d     = grant;
                    state_d = SEL;
                end
            end
            SEL: begin
                out_data_d  = z;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    ack_d       = 4'b0001 << s_q;
                    last_d      = s_q;
                    xfer_cnt_d  = xfer_cnt_q + CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s_q         <= 2'b00;
            last_q      <= 2'd3;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ack_q       <= 4'b0000;
            xfer_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            last_q      <= last_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ack_q       <= ack_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign s         = s_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign ack       = ack_q;
    assign busy      = (state_q != IDLE);
    assign xfer_cnt  = xfer_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_sequencer.sv
`default_nettype none
// ============================================================================
// tb_mux4_rr_sequencer : scoreboard bench with a modelled 4:1 mux on z
// Revision 1.0
// ============================================================================
module tb_mux4_rr_sequencer;

    localparam int W     = 8;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic [3:0]       req;
    logic [W-1:0]     z;
    logic [1:0]       s;
    logic [W-1:0]     out_data;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       ack;
    logic             busy;
    logic [CNT_W-1:0] xfer_cnt;

    typedef struct {
        logic [7:0] data;
        logic [3:0] ack;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] lut [4];
    int         total;
    int         bad;
    logic [7:0] cap_data;
    bit         cap_vld;
    logic [CNT_W-1:0] cnt_m;

    mux4_rr_sequencer #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .z         (z),
        .s         (s),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ack       (ack),
        .busy      (busy),
        .xfer_cnt  (xfer_cnt)
    );

    initial begin
        lut[0] = 8'h00;
        lut[1] = 8'h0F;
        lut[2] = 8'hF0;
        lut[3] = 8'hFF;
    end

    always_comb begin
        case (s)
            2'd0:    z = 8'h00;
            2'd1:    z = 8'h0F;
            2'd2:    z = 8'hF0;
            default: z = 8'hFF;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int src);
        exp_t e;
        e.data = lut[src];
        e.ack  = 4'b0001 << src;
        sb.push_back(e);
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag, input int max_cyc);
        int n;
        n = 0;
        while ((busy || sb.size() != 0 || ack != 4'b0000) && n < max_cyc) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, 32'(n >= max_cyc), 32'd0);
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    // Acks are matched against the word captured on the preceding handshake.
    always @(negedge clk) begin
        if (rst_n && ack != 4'b0000) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_ack", 32'(ack), 32'(e.ack));
                chk("sb_data", 32'(cap_data), 32'(e.data));
                chk("sb_cap_vld", 32'(cap_vld), 32'd1);
            end
            cap_vld = 1'b0;
        end
        if (out_valid && out_ready) begin
            cap_data = out_data;
            cap_vld  = 1'b1;
        end
    end

    initial begin
        total     = 0;
        bad       = 0;
        cap_data  = '0;
        cap_vld   = 1'b0;
        rst_n     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b0;

        // Reset values
        apply_reset();
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(xfer_cnt), 32'd0);

        // Single request from source c
        push(2);
        req       = 4'b0100;
        out_ready = 1'b1;
        tick();
        chk("t1_s", 32'(s), 32'd2);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_valid_early", 32'(out_valid), 32'd0);
        req = 4'b0000;
        tick();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data", 32'(out_data), 32'hF0);
        tick();
        chk("t1_ack", 32'(ack), 32'h4);
        chk("t1_cnt", 32'(xfer_cnt), 32'd1);
        chk("t1_idle", 32'(busy), 32'd0);
        tick();
        chk("t1_ack_pulse", 32'(ack), 32'd0);
        drain("t1", 20);

        // Round robin, all requesting, from a fresh pointer
        apply_reset();
        for (int k = 0; k < 5; k++) push(k % 4);
        req       = 4'b1111;
        out_ready = 1'b1;
        repeat (15) tick();
        req = 4'b0000;
        drain("t2", 20);

        // Backpressure on source d
        out_ready = 1'b0;
        push(3);
        req = 4'b1000;
        tick();
        chk("t3_s", 32'(s), 32'd3);
        req = 4'b0000;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold_valid", 32'(out_valid), 32'd1);
            chk("t3_hold_data", 32'(out_data), 32'hFF);
            chk("t3_hold_s", 32'(s), 32'd3);
            chk("t3_hold_ack", 32'(ack), 32'd0);
            req = 4'($urandom_range(0, 15));
            tick();
        end
        req       = 4'b0000;
        out_ready = 1'b1;
        drain("t3", 20);

        // Request dropped during SEL
        push(1);
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        tick();
        chk("t4_ack", 32'(ack), 32'h2);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_s_held", 32'(s), 32'd1);
        drain("t4", 20);

        // Asynchronous reset in HOLD
        out_ready = 1'b0;
        req       = 4'b1000;
        tick();
        req = 4'b0000;
        tick();
        chk("t5_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", 32'(out_valid), 32'd0);
        chk("t5_async_s", 32'(s), 32'd0);
        chk("t5_async_ack", 32'(ack), 32'd0);
        chk("t5_async_busy", 32'(busy), 32'd0);
        chk("t5_async_cnt", 32'(xfer_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        push(0);
        req       = 4'b1111;
        out_ready = 1'b1;
        tick();
        chk("t5_first_s", 32'(s), 32'd0);
        tick();
        tick();
        req = 4'b0000;
        drain("t5", 20);

        // Counter wrap: pointer is now 0, counter is 1
        cnt_m = CNT_W'(1);
        chk("t6_cnt_start", 32'(xfer_cnt), 32'(cnt_m));
        for (int k = 0; k < 255; k++) push((k + 1) % 4);
        req       = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 255; k++) begin
            repeat (3) tick();
            cnt_m = cnt_m + CNT_W'(1);
            chk("t6_cnt", 32'(xfer_cnt), 32'(cnt_m));
        end
        req = 4'b0000;
        chk("t6_wrapped", 32'(xfer_cnt), 32'd0);
        drain("t6", 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
